// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;

    localparam int DEPTH_DEFAULT  = 16384;
    localparam int ADDR_W_DEFAULT = 14;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/le_word_assembler.sv
// Collects bytes into a little-endian 32-bit word; word_valid_o flags the 4th byte
// so the caller can register the completed word on that same edge.
module le_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_vld_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;

    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (byte_vld_i) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    buf_d[7:0]   = byte_i;
                2'd1:    buf_d[15:8]  = byte_i;
                2'd2:    buf_d[23:16] = byte_i;
                default: buf_d        = buf_q;
            endcase
        end
    end

    // The top byte bypasses the buffer so the full word is visible on its arrival.
    assign word_valid_o = byte_vld_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {byte_i, buf_q};

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt_q <= 2'd0;
            buf_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes the image into instruction memory and holds the core
// in reset until complete. Define LOADER_CHECKSUM_EN to require a trailing 32-bit checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   words_loaded
);

    state_e              state_q;
    logic                rx_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_waddr_q;
    logic [31:0]         mem_wdata_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                cpu_hold_q;
    logic [ADDR_W:0]     words_loaded_q;
    logic [ADDR_W:0]     n_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]         sum_q;
`endif

    logic                byte_vld;
    logic                asm_clear;
    logic [31:0]         word;
    logic                word_valid;
    logic [ADDR_W:0]     wl_next;

    assign byte_vld  = rx_valid && rx_ready_q;
    assign asm_clear = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign wl_next   = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};

    le_word_assembler u_asm (
        .clk_i        (clk),
        .reset_i      (reset),
        .clear_i      (asm_clear),
        .byte_i       (rx_data),
        .byte_vld_i   (byte_vld),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rx_ready_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_waddr_q    <= '0;
            mem_wdata_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_hold_q     <= 1'b1;
            words_loaded_q <= '0;
            n_q            <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q        <= LEN;
                        rx_ready_q     <= 1'b1;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                        cpu_hold_q     <= 1'b1;
                        words_loaded_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q          <= '0;
`endif
                    end
                end
                LEN: begin
                    if (word_valid) begin
                        n_q <= word[ADDR_W:0];
                        if (word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q    <= CHK;
`else
                            state_q    <= DONE;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
`endif
                        end else if (word > 32'(DEPTH)) begin
                            state_q    <= ERROR;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        // words_loaded doubles as the word index: it counts writes from zero.
                        mem_we_q       <= 1'b1;
                        mem_waddr_q    <= words_loaded_q[ADDR_W-1:0];
                        mem_wdata_q    <= word;
                        words_loaded_q <= wl_next;
`ifdef LOADER_CHECKSUM_EN
                        sum_q          <= sum_q + word;
`endif
                        if (wl_next == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q    <= CHK;
`else
                            state_q    <= DONE;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (word_valid) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (word == sum_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q    <= ERROR;
                            error_q    <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_waddr    = mem_waddr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = cpu_hold_q;
    assign words_loaded = words_loaded_q;

endmodule
